trace_fetch: RTL and testbench

TRACE_FETCH -- requirements
Module: trace_fetch

---
 rtl/trace_fetch_if.sv | 22 ++
 rtl/trace_fetch.sv | 154 +++++++++++++++
 tb/tb_trace_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_fetch_if.sv
// Port-B read bus between trace_fetch (master) and the RAM arbiter (slave).
// Ports: wr_busy (writer owns port B), mem_rd/mem_addr (read), mem_rdata (data, 1 cycle later).
interface trace_fetch_if;
    logic        wr_busy;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        input  wr_busy,
        input  mem_rdata,
        output mem_rd,
        output mem_addr
    );

    modport slave (
        output wr_busy,
        output mem_rdata,
        input  mem_rd,
        input  mem_addr
    );
endinterface

// File: rtl/trace_fetch.sv
// Copies the EMG and ECG sample rings into column buffers once per frame and draws them.
// Ports: clock, reset (async, active-high), frame_start, head_emg/head_ecg, mem (port-B bus),
//        pix_x/pix_y in; trace_emg/trace_ecg (1-cycle latency), busy, done out.
module trace_fetch #(
    parameter logic [11:0] EMG_BASE = 12'hC7F,
    parameter logic [11:0] ECG_BASE = 12'h801,
    parameter int          DEPTH    = 640
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [9:0]           head_emg,
    input  logic [9:0]           head_ecg,
    trace_fetch_if.master        mem,
    input  logic [9:0]           pix_x,
    input  logic [8:0]           pix_y,
    output logic                 trace_emg,
    output logic                 trace_ecg,
    output logic                 busy,
    output logic                 done
);
    localparam logic [9:0]  LAST    = 10'(DEPTH - 1);
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    typedef enum logic [1:0] {IDLE, EMG, ECG, DRAIN} state_t;

    state_t      state;
    logic [9:0]  col;
    logic [9:0]  start_emg;
    logic [9:0]  start_ecg;
    logic        valid;

    logic        cap_rd;
    logic        cap_ecg;
    logic [9:0]  cap_col;

    logic [7:0]  emg_buf [DEPTH];
    logic [7:0]  ecg_buf [DEPTH];

    logic        issue;
    logic [10:0] sum;
    logic [9:0]  idx;
    logic [7:0]  inv;
    logic [7:0]  y_new;
    logic        in_range;
    logic [9:0]  rd_x;
    logic [7:0]  emg_pix;
    logic [7:0]  ecg_pix;

    // Reads are gated combinationally so a wr_busy cycle never carries a read.
    always_comb begin
        issue = ((state == EMG) || (state == ECG)) && !mem.wr_busy;
        sum   = {1'b0, (state == ECG) ? start_ecg : start_emg} + {1'b0, col};
        idx   = (sum >= DEPTH_W) ? 10'(sum - DEPTH_W) : sum[9:0];
    end

    assign mem.mem_rd   = issue;
    assign mem.mem_addr = issue
        ? (((state == ECG) ? ECG_BASE : EMG_BASE) + {2'b00, idx})
        : 12'h000;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            start_emg <= '0;
            start_ecg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            cap_rd    <= 1'b0;
            cap_ecg   <= 1'b0;
            cap_col   <= '0;
        end else begin
            done    <= 1'b0;
            cap_rd  <= issue;
            cap_ecg <= (state == ECG);
            cap_col <= col;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        start_emg <= head_emg;
                        start_ecg <= head_ecg;
                        col       <= '0;
                        busy      <= 1'b1;
                        state     <= EMG;
                    end
                end
                EMG: begin
                    if (issue) begin
                        if (col == LAST) begin
                            col   <= '0;
                            state <= ECG;
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
                ECG: begin
                    if (issue) begin
                        if (col == LAST) begin
                            col   <= '0;
                            state <= DRAIN;
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Screen row is inverted sample, clipped to the 240-line half.
    always_comb begin
        inv   = 8'hFF - mem.mem_rdata[11:4];
        y_new = (inv > 8'd239) ? 8'd239 : inv;
    end

    // Buffers hold no reset; valid masks stale contents.
    always_ff @(posedge clock) begin
        if (cap_rd && !cap_ecg) begin
            emg_buf[cap_col] <= y_new;
        end
        if (cap_rd && cap_ecg) begin
            ecg_buf[cap_col] <= y_new;
        end
    end

    always_comb begin
        in_range = (pix_x < 10'(DEPTH));
        rd_x     = in_range ? pix_x : '0;
        emg_pix  = emg_buf[rd_x];
        ecg_pix  = ecg_buf[rd_x];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trace_emg <= 1'b0;
            trace_ecg <= 1'b0;
        end else begin
            trace_emg <= valid && in_range
                && (pix_y == {1'b0, emg_pix});
            trace_ecg <= valid && in_range
                && (pix_y == (9'd240 + {1'b0, ecg_pix}));
        end
    end
endmodule

// File: tb/tb_trace_fetch.sv
// Bench for trace_fetch: RAM model, queue-based address model, directed literal checks.
// Ports: none.
module tb_trace_fetch;
    localparam int DEPTH    = 640;
    localparam int EMG_BASE = 'hC7F;
    localparam int ECG_BASE = 'h801;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] head_emg = '0;
    logic [9:0] head_ecg = '0;
    logic [9:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic       trace_emg;
    logic       trace_ecg;
    logic       busy;
    logic       done;

    trace_fetch_if mif();

    trace_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .head_emg    (head_emg),
        .head_ecg    (head_ecg),
        .mem         (mif),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .trace_emg   (trace_emg),
        .trace_ecg   (trace_ecg),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [4096];

    always @(posedge clock) mif.mem_rdata <= ram[mif.mem_addr];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          acc_cyc = 0;
    int          last_lat = 0;
    int          done_count = 0;
    int          q[$];
    logic [11:0] alog[$];
    bit          m_busy = 0;
    bit          m_valid = 0;
    bit          p_valid = 0;
    bit          p_idle = 0;
    int          p_x = 0;
    int          p_y = 0;
    int          mh_emg = 0;
    int          mh_ecg = 0;
    int          m_emg [DEPTH];
    int          m_ecg [DEPTH];
    bit          exp_done;
    bit          exp_e;
    bit          exp_c;
    int          ea;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int yv(input logic [31:0] w);
        int v;
        v = 255 - int'(w[11:4]);
        return (v > 239) ? 239 : v;
    endfunction

    function automatic logic [31:0] la(input int i);
        if (i < alog.size()) return {20'h0, alog[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // Model and per-cycle compare.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_mem_rd", {31'b0, mif.mem_rd}, 0);
            chk("rst_mem_addr", {20'b0, mif.mem_addr}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_done", {31'b0, done}, 0);
            chk("rst_trace_emg", {31'b0, trace_emg}, 0);
            chk("rst_trace_ecg", {31'b0, trace_ecg}, 0);
            q.delete();
            m_busy   = 0;
            m_valid  = 0;
            done_cyc = -1;
            p_valid  = 0;
            p_idle   = 1;
        end else begin
            exp_done = (cyc == done_cyc);
            if (exp_done) m_busy = 0;
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, exp_done});
            if (mif.mem_rd) begin
                if (mif.wr_busy) chk("rd_while_wr_busy", 1, 0);
                if (q.size() == 0) begin
                    chk("unexpected_rd", 1, 0);
                end else begin
                    ea = q.pop_front();
                    chk("mem_addr", {20'b0, mif.mem_addr}, ea);
                    alog.push_back(mif.mem_addr);
                    if (q.size() == 0) done_cyc = cyc + 2;
                end
            end else if (m_busy && !mif.wr_busy && q.size() != 0) begin
                chk("missing_rd", 0, 1);
            end
            if (!p_valid || p_x >= DEPTH) begin
                chk("trace_emg_off", {31'b0, trace_emg}, 0);
                chk("trace_ecg_off", {31'b0, trace_ecg}, 0);
            end else if (p_idle) begin
                exp_e = (p_y == m_emg[p_x]);
                exp_c = (p_y == 240 + m_ecg[p_x]);
                chk("trace_emg", {31'b0, trace_emg}, {31'b0, exp_e});
                chk("trace_ecg", {31'b0, trace_ecg}, {31'b0, exp_c});
            end
            if (exp_done) begin
                for (int c = 0; c < DEPTH; c++) begin
                    m_emg[c] = yv(ram[(EMG_BASE + (mh_emg + c) % DEPTH) % 4096]);
                    m_ecg[c] = yv(ram[(ECG_BASE + (mh_ecg + c) % DEPTH) % 4096]);
                end
                m_valid = 1;
                done_count++;
                last_lat = cyc - acc_cyc;
            end
            if (frame_start && !m_busy) begin
                m_busy  = 1;
                acc_cyc = cyc;
                mh_emg  = int'(head_emg);
                mh_ecg  = int'(head_ecg);
                alog.delete();
                q.delete();
                for (int c = 0; c < DEPTH; c++)
                    q.push_back((EMG_BASE + (mh_emg + c) % DEPTH) % 4096);
                for (int c = 0; c < DEPTH; c++)
                    q.push_back((ECG_BASE + (mh_ecg + c) % DEPTH) % 4096);
            end
            p_valid = m_valid;
            p_idle  = !m_busy;
        end
        p_x = int'(pix_x);
        p_y = int'(pix_y);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int dc;
        int n;
        dc = done_count;
        n = 0;
        while (done_count == dc && n < limit) begin
            pix_x = 10'(n % 700);
            pix_y = 9'((n * 7) % 512);
            step();
            n++;
        end
        chk("done_timeout", {31'b0, done_count != dc}, 1);
    endtask

    task automatic wait_log(input int target, input int limit);
        int n;
        n = 0;
        while (alog.size() < target && n < limit) begin
            step();
            n++;
        end
        chk("log_timeout", {31'b0, alog.size() >= target}, 1);
    endtask

    task automatic lit_pix(input int x, input int y, input bit e,
                           input bit c, input string nm);
        pix_x = 10'(x);
        pix_y = 9'(y);
        @(posedge clock);
        @(negedge clock);
        chk({nm, "_emg"}, {31'b0, trace_emg}, {31'b0, e});
        chk({nm, "_ecg"}, {31'b0, trace_ecg}, {31'b0, c});
        step();
    endtask

    task automatic sweep();
        for (int x = 0; x < DEPTH + 4; x++) begin
            pix_x = 10'(x);
            pix_y = (x < DEPTH) ? 9'(m_emg[x]) : 9'd0;
            step();
            pix_y = (x < DEPTH) ? 9'(240 + m_ecg[x]) : 9'd300;
            step();
        end
    endtask

    task automatic fill_index();
        for (int a = 0; a < 4096; a++) ram[a] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[EMG_BASE + i] = 32'(i);
            ram[ECG_BASE + i] = 32'(i);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            ram[EMG_BASE + i] = {20'h0, 8'(i * 7), 4'h5};
            ram[ECG_BASE + i] = {20'h0, 8'(i * 7 + 3), 4'h5};
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc;
        mif.wr_busy = 1'b0;
        fill_index();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("init_busy", {31'b0, busy}, 0);
        chk("init_mem_rd", {31'b0, mif.mem_rd}, 0);
        step();
        reset = 1'b0;
        step();

        // First fetch: no valid data yet, heads at 0.
        pulse();
        wait_log(10, 100);
        lit_pix(5, 239, 0, 0, "A_masked");
        wait_done(3000);
        chk("A_latency", 32'(last_lat), 1282);
        chk("A_reads", 32'(alog.size()), 1280);
        chk("A_emg_first", la(0), 32'hC7F);
        chk("A_emg_last", la(639), 32'hEFE);
        chk("A_ecg_first", la(640), 32'h801);
        chk("A_ecg_last", la(1279), 32'hA80);
        sweep();

        // Wrapped ring start.
        head_emg = 10'd600;
        head_ecg = 10'd5;
        pulse();
        wait_done(3000);
        chk("B_col0", la(0), 32'hED7);
        chk("B_col39", la(39), 32'hEFE);
        chk("B_col40", la(40), 32'hC7F);
        chk("B_ecg_col0", la(640), 32'h806);
        lit_pix(0, 218, 1, 0, "B_pix0");
        lit_pix(0, 479, 0, 1, "B_pix0_ecg");
        lit_pix(640, 218, 0, 0, "B_pix640");
        sweep();

        // Writer stall of 3 cycles at column 100.
        fill_pattern();
        head_emg = 10'd0;
        head_ecg = 10'd0;
        pulse();
        wait_log(100, 300);
        mif.wr_busy = 1'b1;
        repeat (3) step();
        mif.wr_busy = 1'b0;
        wait_done(3000);
        chk("C_latency", 32'(last_lat), 1285);
        chk("C_reads", 32'(alog.size()), 1280);
        chk("C_col99", la(99), 32'hCE2);
        chk("C_col100", la(100), 32'hCE3);
        sweep();

        // Saturation extremes at column 5.
        ram[EMG_BASE + 5] = 32'h0000_0000;
        ram[ECG_BASE + 5] = 32'h0000_0FFF;
        pulse();
        wait_done(3000);
        lit_pix(5, 239, 1, 0, "D_emg5");
        lit_pix(6, 239, 0, 0, "D_emg6");
        lit_pix(5, 240, 0, 1, "D_ecg5");
        lit_pix(4, 240, 0, 0, "D_ecg4");

        // frame_start while busy is dropped.
        dc = done_count;
        pulse();
        wait_log(300, 600);
        pulse();
        wait_done(3000);
        repeat (30) step();
        chk("E_single_done", 32'(done_count), 32'(dc + 1));
        chk("E_latency", 32'(last_lat), 1282);

        // Reset mid-fetch.
        pulse();
        wait_log(300, 600);
        reset = 1'b1;
        @(negedge clock);
        chk("R_busy", {31'b0, busy}, 0);
        step();
        reset = 1'b0;
        step();
        lit_pix(5, 239, 0, 0, "R_masked");
        sweep();
        pulse();
        wait_log(10, 100);
        lit_pix(5, 239, 0, 0, "R_during");
        wait_done(3000);
        chk("R_latency", 32'(last_lat), 1282);
        chk("R_reads", 32'(alog.size()), 1280);
        lit_pix(5, 239, 1, 0, "R_after");
        lit_pix(1023, 239, 0, 0, "R_pix1023");

        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
